// File: rtl/axi_tdd_channel_monitor_if.sv
// Shared TDD controller types plus the bus bundle of the TDD channel monitor.
// Latency: n/a (type and signal definitions only).
// Backpressure: none; every signal is a level or a single-cycle pulse.
//
// Package axi_tdd_pkg : state_t, the TDD controller state (IDLE/ARMED/WAITING/RUNNING).
// Interface ports (master = controller/register-map side, slave = monitor):
//   tdd_counter, tdd_cstate, tdd_enable, tdd_endof_frame : controller timing inputs
//   ch_en, asy_ch_pol, clr_status                        : register-map controls
//   t_high_meas, t_low_meas, meas_valid                  : published measurement pair
//   err_no_high, err_no_low, err_extra                   : sticky error flags
package axi_tdd_pkg;
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    WAITING = 2'd2,
    RUNNING = 2'd3
  } state_t;
endpackage

interface axi_tdd_channel_monitor_if #(
  parameter int REGISTER_WIDTH = 32
);
  logic [REGISTER_WIDTH-1:0] tdd_counter;
  axi_tdd_pkg::state_t       tdd_cstate;
  logic                      tdd_enable;
  logic                      tdd_endof_frame;
  logic                      ch_en;
  logic                      asy_ch_pol;
  logic                      clr_status;
  logic [REGISTER_WIDTH-1:0] t_high_meas;
  logic [REGISTER_WIDTH-1:0] t_low_meas;
  logic                      meas_valid;
  logic                      err_no_high;
  logic                      err_no_low;
  logic                      err_extra;

  modport master (
    output tdd_counter, tdd_cstate, tdd_enable, tdd_endof_frame,
           ch_en, asy_ch_pol, clr_status,
    input  t_high_meas, t_low_meas, meas_valid,
           err_no_high, err_no_low, err_extra
  );

  modport slave (
    input  tdd_counter, tdd_cstate, tdd_enable, tdd_endof_frame,
           ch_en, asy_ch_pol, clr_status,
    output t_high_meas, t_low_meas, meas_valid,
           err_no_high, err_no_low, err_extra
  );
endinterface

// File: rtl/axi_tdd_channel_monitor.sv
// Measures per frame the TDD counter values at which an external async line asserts/deasserts.
// Latency: meas_valid SYNC_STAGES+1 cycles after tdd_endof_frame (SYNC_STAGES+GLITCH_CYCLES with filter).
// Backpressure: none; results are published as a one-cycle pulse with held values.
//
// Ports: clk (only clock), resetn (async active-low), in (async monitored line),
//        bus (axi_tdd_channel_monitor_if.slave: controller timing, register-map controls,
//        measurement outputs and sticky error flags).
// Optional feature: define AXI_TDD_CHANNEL_MONITOR_GLITCH_FILTER_EN to add a stability
// filter of GLITCH_CYCLES samples on the synchronized line.
module axi_tdd_channel_monitor #(
  parameter bit DEFAULT_POLARITY = 1'b0,
  parameter int REGISTER_WIDTH   = 32,
  parameter int SYNC_STAGES      = 2,
  parameter int GLITCH_CYCLES    = 4
) (
  input logic                     clk,
  input logic                     resetn,
  input logic                     in,
  axi_tdd_channel_monitor_if.slave bus
);

`ifdef AXI_TDD_CHANNEL_MONITOR_GLITCH_FILTER_EN
  localparam bit GLITCH_EN = 1'b1;
`else
  localparam bit GLITCH_EN = 1'b0;
`endif
  // Timing side-band is delayed exactly as long as the line sample, so a
  // level change lines up with the counter value seen when it entered stage 1.
  localparam int ALIGN = SYNC_STAGES + (GLITCH_EN ? GLITCH_CYCLES - 1 : 0);

  typedef enum logic [1:0] {
    M_IDLE     = 2'd0,
    M_WAIT_SET = 2'd1,
    M_WAIT_RST = 2'd2,
    M_DONE     = 2'd3
  } mon_state_t;

  logic [SYNC_STAGES-1:0]    sync_q;
  logic                      sync_out;
  logic                      lvl;
  logic                      prev_q;
  logic                      ch_pol;
  logic                      mon_en;
  logic [REGISTER_WIDTH-1:0] cnt_pipe [ALIGN];
  logic [ALIGN-1:0]          run_pipe;
  logic [ALIGN-1:0]          eof_pipe;
  logic                      run_al;
  logic                      eof_al;
  logic                      act;
  logic                      act_prev;
  logic                      assert_e;
  logic                      deassert_e;

  mon_state_t                st;
  mon_state_t                st_post;
  logic [REGISTER_WIDTH-1:0] t_high_cap, t_low_cap;
  logic [REGISTER_WIDTH-1:0] hi_nxt, lo_nxt;
  logic                      extra_hit;
  logic [REGISTER_WIDTH-1:0] t_high_q, t_low_q;
  logic                      mv_q, err_no_high_q, err_no_low_q, err_extra_q;

  assign sync_out = sync_q[SYNC_STAGES-1];

`ifdef AXI_TDD_CHANNEL_MONITOR_GLITCH_FILTER_EN
  // hist_q keeps the previous GLITCH_CYCLES-1 samples; together with the
  // current one they must all agree before the filtered level moves.
  logic [GLITCH_CYCLES-2:0] hist_q;
  logic                     stable;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      hist_q <= {(GLITCH_CYCLES-1){DEFAULT_POLARITY}};
    end else begin
      hist_q[0] <= sync_out;
      for (int i = 1; i < GLITCH_CYCLES - 1; i++) hist_q[i] <= hist_q[i-1];
    end
  end

  assign stable = (hist_q == {(GLITCH_CYCLES-1){sync_out}});
  assign lvl    = stable ? sync_out : prev_q;
`else
  assign lvl = sync_out;
`endif

  // Synchronizer, polarity/enable latches, previous level and alignment pipes.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync_q   <= {SYNC_STAGES{DEFAULT_POLARITY}};
      prev_q   <= DEFAULT_POLARITY;
      ch_pol   <= DEFAULT_POLARITY;
      mon_en   <= 1'b0;
      run_pipe <= '0;
      eof_pipe <= '0;
      for (int i = 0; i < ALIGN; i++) cnt_pipe[i] <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], in};
      prev_q <= lvl;
      if (bus.tdd_enable) ch_pol <= bus.asy_ch_pol;
      if (bus.tdd_cstate == axi_tdd_pkg::IDLE)
        mon_en <= 1'b0;
      else if (bus.tdd_cstate == axi_tdd_pkg::ARMED || bus.tdd_endof_frame)
        mon_en <= bus.ch_en;
      run_pipe    <= {run_pipe[ALIGN-2:0], (bus.tdd_cstate == axi_tdd_pkg::RUNNING)};
      eof_pipe    <= {eof_pipe[ALIGN-2:0], bus.tdd_endof_frame};
      cnt_pipe[0] <= bus.tdd_counter;
      for (int i = 1; i < ALIGN; i++) cnt_pipe[i] <= cnt_pipe[i-1];
    end
  end

  assign run_al = run_pipe[ALIGN-1];
  assign eof_al = eof_pipe[ALIGN-1];

  // Edges are judged with the current polarity on both samples, so a polarity
  // change alone never looks like a line transition.
  assign act        = lvl ^ ch_pol;
  assign act_prev   = prev_q ^ ch_pol;
  assign assert_e   = act & ~act_prev;
  assign deassert_e = ~act & act_prev;

  // Edge handling first; end-of-frame decisions use the post-edge state.
  always_comb begin
    st_post   = st;
    hi_nxt    = t_high_cap;
    lo_nxt    = t_low_cap;
    extra_hit = 1'b0;
    case (st)
      M_WAIT_SET: if (assert_e) begin
        hi_nxt  = cnt_pipe[ALIGN-1];
        st_post = M_WAIT_RST;
      end
      M_WAIT_RST: if (deassert_e) begin
        lo_nxt  = cnt_pipe[ALIGN-1];
        st_post = M_DONE;
      end
      M_DONE:  extra_hit = assert_e;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      st            <= M_IDLE;
      t_high_cap    <= '0;
      t_low_cap     <= '0;
      t_high_q      <= '0;
      t_low_q       <= '0;
      mv_q          <= 1'b0;
      err_no_high_q <= 1'b0;
      err_no_low_q  <= 1'b0;
      err_extra_q   <= 1'b0;
    end else begin
      mv_q <= 1'b0;
      // Clear first so a same-cycle set below takes precedence.
      if (bus.clr_status) begin
        err_no_high_q <= 1'b0;
        err_no_low_q  <= 1'b0;
        err_extra_q   <= 1'b0;
      end
      if (bus.tdd_cstate == axi_tdd_pkg::IDLE) begin
        // Controller stopped: drop the partial frame silently.
        st <= M_IDLE;
      end else if (st == M_IDLE) begin
        if (run_al && mon_en) st <= M_WAIT_SET;
      end else begin
        t_high_cap <= hi_nxt;
        t_low_cap  <= lo_nxt;
        if (extra_hit) err_extra_q <= 1'b1;
        if (eof_al) begin
          case (st_post)
            M_DONE: begin
              t_high_q <= hi_nxt;
              t_low_q  <= lo_nxt;
              mv_q     <= 1'b1;
            end
            M_WAIT_SET: err_no_high_q <= 1'b1;
            M_WAIT_RST: err_no_low_q  <= 1'b1;
            default: ;
          endcase
          st <= mon_en ? M_WAIT_SET : M_IDLE;
        end else begin
          st <= st_post;
        end
      end
    end
  end

  assign bus.t_high_meas = t_high_q;
  assign bus.t_low_meas  = t_low_q;
  assign bus.meas_valid  = mv_q;
  assign bus.err_no_high = err_no_high_q;
  assign bus.err_no_low  = err_no_low_q;
  assign bus.err_extra   = err_extra_q;

endmodule

// File: tb/tb_axi_tdd_channel_monitor.sv
// Self-checking bench for axi_tdd_channel_monitor: frames of 100 counts with scripted pulses.
// Expected publishes are queued when the end-of-frame pulse is driven and checked on meas_valid.
// Sticky flags and held values are checked directly after each frame.
module tb_axi_tdd_channel_monitor;
  localparam int RW = 32;
  localparam int S  = 2;
  localparam int G  = 4;
`ifdef AXI_TDD_CHANNEL_MONITOR_GLITCH_FILTER_EN
  localparam int LAT = S + G;
`else
  localparam int LAT = S + 1;
`endif

  typedef struct {
    int hi;
    int lo;
    int at;
  } exp_t;

  logic clk    = 1'b0;
  logic resetn = 1'b0;
  logic in_line = 1'b0;
  logic pol_tb = 1'b0;
  int   cyc    = 0;
  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t exp_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  axi_tdd_channel_monitor_if #(.REGISTER_WIDTH(RW)) bus ();

  axi_tdd_channel_monitor #(
    .DEFAULT_POLARITY(1'b0),
    .REGISTER_WIDTH  (RW),
    .SYNC_STAGES     (S),
    .GLITCH_CYCLES   (G)
  ) dut (
    .clk   (clk),
    .resetn(resetn),
    .in    (in_line),
    .bus   (bus.slave)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk_flags(input string tag, input bit nh, input bit nl, input bit ex);
    chk({tag, "_no_high"}, bus.err_no_high, nh);
    chk({tag, "_no_low"},  bus.err_no_low,  nl);
    chk({tag, "_extra"},   bus.err_extra,   ex);
  endtask

  task automatic go_idle();
    bus.tdd_cstate      = axi_tdd_pkg::IDLE;
    bus.tdd_endof_frame = 1'b0;
    bus.tdd_counter     = '0;
    in_line             = pol_tb;
    step(8);
  endtask

  task automatic arm();
    bus.tdd_cstate = axi_tdd_pkg::IDLE;
    step(3);
    bus.tdd_cstate = axi_tdd_pkg::ARMED;
    step(3);
    bus.tdd_cstate = axi_tdd_pkg::WAITING;
    step(2);
    bus.tdd_cstate = axi_tdd_pkg::RUNNING;
  endtask

  // One frame of counts 0..99; the line is active for a0<=c<b0 or a1<=c<b1.
  task automatic frame(input int a0, input int b0, input int a1, input int b1,
                       input bit pub, input int eh, input int el);
    exp_t e;
    for (int c = 0; c < 100; c++) begin
      bus.tdd_counter     = c;
      in_line             = (((c >= a0) && (c < b0)) || ((c >= a1) && (c < b1))) ^ pol_tb;
      bus.tdd_endof_frame = (c == 99);
      if (c == 99 && pub) begin
        e.hi = eh;
        e.lo = el;
        e.at = cyc + LAT;
        exp_q.push_back(e);
      end
      step(1);
    end
    bus.tdd_endof_frame = 1'b0;
  endtask

  // Counts 0..upto-1 only, line active from count a on; no end of frame.
  task automatic partial(input int upto, input int a);
    for (int c = 0; c < upto; c++) begin
      bus.tdd_counter = c;
      in_line         = (c >= a) ^ pol_tb;
      step(1);
    end
  endtask

  task automatic clear_status();
    bus.clr_status = 1'b1;
    step(1);
    bus.clr_status = 1'b0;
    step(1);
  endtask

  // Scoreboard: every meas_valid must match the oldest queued expectation.
  always @(negedge clk) begin
    if (resetn && bus.meas_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_meas_valid", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("pub_t_high", bus.t_high_meas, e.hi);
        chk("pub_t_low",  bus.t_low_meas,  e.lo);
        chk("pub_latency", cyc, e.at);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.tdd_counter     = '0;
    bus.tdd_cstate      = axi_tdd_pkg::IDLE;
    bus.tdd_enable      = 1'b1;
    bus.tdd_endof_frame = 1'b0;
    bus.ch_en           = 1'b1;
    bus.asy_ch_pol      = 1'b0;
    bus.clr_status      = 1'b0;
    #23;
    // Reset state.
    chk("rst_t_high", bus.t_high_meas, 0);
    chk("rst_t_low",  bus.t_low_meas,  0);
    chk("rst_meas_valid", bus.meas_valid, 0);
    chk_flags("rst", 0, 0, 0);
    resetn = 1'b1;
    step(4);

    // Baseline pulse 10..29.
    arm();
    frame(10, 30, -1, -1, 1, 10, 30);
    step(LAT + 2);
    chk_flags("base", 0, 0, 0);
    chk("base_hold_high", bus.t_high_meas, 10);
    chk("base_hold_low",  bus.t_low_meas,  30);

    // Missing pulse keeps previous values and raises err_no_high.
    frame(-1, -1, -1, -1, 0, 0, 0);
    step(LAT + 2);
    chk_flags("miss", 1, 0, 0);
    chk("miss_hold_high", bus.t_high_meas, 10);
    chk("miss_hold_low",  bus.t_low_meas,  30);
    clear_status();
    chk_flags("miss_clr", 0, 0, 0);

    // Double pulse, held pulse, then carried-over deassertion ignored.
    frame(5, 10, 40, 50, 1, 5, 10);
    step(LAT + 2);
    chk_flags("dbl", 0, 0, 1);
    frame(60, 200, -1, -1, 0, 0, 0);
    step(LAT + 2);
    chk_flags("held", 0, 1, 1);
    chk("held_keep_high", bus.t_high_meas, 5);
    frame(0, 5, 20, 30, 1, 20, 30);
    step(LAT + 2);
    chk_flags("carry", 0, 1, 1);
    clear_status();
    chk_flags("carry_clr", 0, 0, 0);

    // Inverted polarity: line idles high, active-low pulse 10..29.
    go_idle();
    pol_tb         = 1'b1;
    bus.asy_ch_pol = 1'b1;
    go_idle();
    arm();
    frame(10, 30, -1, -1, 1, 10, 30);
    step(LAT + 2);
    chk_flags("inv", 0, 0, 0);
    go_idle();
    pol_tb         = 1'b0;
    bus.asy_ch_pol = 1'b0;
    go_idle();

    // Two-cycle glitch at count 50.
    arm();
`ifdef AXI_TDD_CHANNEL_MONITOR_GLITCH_FILTER_EN
    frame(50, 52, -1, -1, 0, 0, 0);
    step(LAT + 2);
    chk_flags("glitch", 1, 0, 0);
`else
    frame(50, 52, -1, -1, 1, 50, 52);
    step(LAT + 2);
    chk_flags("glitch", 0, 0, 0);
`endif
    clear_status();

    // Abort: controller drops to IDLE after an assertion.
    partial(50, 20);
    bus.tdd_cstate = axi_tdd_pkg::IDLE;
    in_line        = pol_tb;
    step(LAT + 4);
    chk("abort_state", int'(dut.st), 0);
    chk_flags("abort", 0, 0, 0);
    chk("abort_queue", exp_q.size(), 0);

    // Asynchronous reset mid-frame clears outputs at once.
    arm();
    frame(10, 30, -1, -1, 1, 10, 30);
    frame(-1, -1, -1, -1, 0, 0, 0);
    partial(40, 20);
    chk("pre_rst_no_high", bus.err_no_high, 1);
    #1;
    resetn = 1'b0;
    #1;
    chk("arst_t_high", bus.t_high_meas, 0);
    chk("arst_t_low",  bus.t_low_meas,  0);
    chk_flags("arst", 0, 0, 0);
    step(2);
    go_idle();
    resetn = 1'b1;
    step(4);

    chk("sb_drain", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/axi_tdd_channel_monitor.md
Name: axi_tdd_channel_monitor

Overview:
Receive-side counterpart of the TDD channel output generator. It samples an external, asynchronous TDD control line and measures, per frame, the frame-counter values at which the line asserts and deasserts. The block runs in the axi_tdd core clock domain, shares the frame counter and state from the TDD controller, and reports per-frame measurements plus sticky error flags to the register map. It is used to verify board-level timing of TDD lines and to characterise externally driven TDD lines.

Parameters:
DEFAULT_POLARITY, 0, idle level of the monitored line, and reset value of the latched polarity.
REGISTER_WIDTH, 32, width of the counter and of the measured values.
SYNC_STAGES, 2, synchronizer depth for `in`; legal range 2..4.
GLITCH_CYCLES, 4, stability window for the optional filter; legal range 2..16.

Ports:
clk  in  1  core clock; the only clock in the block.
resetn  in  1  asynchronous, active-low reset.
tdd_counter  in  REGISTER_WIDTH  frame counter from the TDD controller.
tdd_cstate  in  axi_tdd_pkg::state_t  controller state: IDLE, ARMED, WAITING or RUNNING.
tdd_enable  in  1  controller enable; asy_ch_pol is latched only while this is high.
tdd_endof_frame  in  1  single-cycle end-of-frame pulse.
ch_en  in  1  monitor enable, from the register map.
asy_ch_pol  in  1  line polarity, from the register map; 1 means the line is active-low.
in  in  1  asynchronous monitored line.
clr_status  in  1  single-cycle pulse that clears the sticky error flags.
t_high_meas  out  REGISTER_WIDTH  counter value at the last valid assertion.
t_low_meas  out  REGISTER_WIDTH  counter value at the last valid deassertion.
meas_valid  out  1  one-cycle pulse when a new measurement pair is published.
err_no_high  out  1  sticky: a frame ended with no assertion.
err_no_low  out  1  sticky: a frame ended asserted but not deasserted.
err_extra  out  1  sticky: more than one pulse occurred in a frame.

Behaviour:
- Reset: all registers are asynchronously cleared.
  - All outputs reset to 0.
  - The synchronizer flops and the previous-level register reset to DEFAULT_POLARITY.
  - The latched polarity ch_pol resets to DEFAULT_POLARITY.
- Polarity latching: ch_pol <= asy_ch_pol only while tdd_enable = 1.
- Monitor enable latching: mon_en <= ch_en when tdd_cstate == ARMED or tdd_endof_frame = 1; mon_en clears when tdd_cstate == IDLE.
- Synchronizer: `in` passes through SYNC_STAGES flops.
- Alignment pipelines: tdd_counter, run = (tdd_cstate == RUNNING) and tdd_endof_frame are each delayed by SYNC_STAGES flops, so they stay aligned with the synchronized sample.
- Timestamp rule: a transition first captured by synchronizer stage 1 at clock edge k is timestamped with the tdd_counter value sampled at edge k.
- Active level and edges: act = sync_out XOR ch_pol. A rising edge of act is an assertion; a falling edge of act is a deassertion.
- FSM states: M_IDLE, M_WAIT_SET, M_WAIT_RST, M_DONE.
  - Any state -> M_IDLE when the undelayed tdd_cstate == IDLE. A partial frame is discarded: no publish and no error.
  - M_IDLE -> M_WAIT_SET when the aligned run = 1 and mon_en = 1.
  - M_WAIT_SET: on an assertion, store the aligned counter as t_high_cap and go to M_WAIT_RST. A deassertion is ignored; this covers a pulse carried over from the previous frame.
  - M_WAIT_RST: on a deassertion, store t_low_cap and go to M_DONE.
  - M_DONE: any assertion sets err_extra.
- End of frame (aligned eof, state not M_IDLE). An edge in the same cycle is processed first; the post-edge state is then evaluated:
  - M_DONE: t_high_meas and t_low_meas are loaded and meas_valid pulses.
  - M_WAIT_SET: err_no_high is set.
  - M_WAIT_RST: err_no_low is set; the outputs are unchanged.
  - Next state is M_WAIT_SET if mon_en = 1, otherwise M_IDLE.
- Latency: meas_valid rises SYNC_STAGES+1 cycles after the tdd_endof_frame input pulse.
- Held values: t_high_meas and t_low_meas hold between publishes.
- Sticky flags: cleared by clr_status. If a set and clr_status occur in the same cycle, the set wins.
- Arithmetic: none; captured values are raw counter values, with no wrap correction.

Optional Feature:
Macro AXI_TDD_CHANNEL_MONITOR_GLITCH_FILTER_EN.
- Defined:
  - act changes only after GLITCH_CYCLES consecutive identical synchronized samples.
  - The counter, run and eof pipelines are lengthened by GLITCH_CYCLES-1 flops, so the timestamp is still that of the first sample at the new level.
  - meas_valid latency becomes SYNC_STAGES+GLITCH_CYCLES cycles.
- Undefined: act follows the synchronized sample directly; there is no filter logic and no extra flops.

Test Plan:
1. Baseline: ch_pol=0, frame of 100 counts (0..99), `in` high for counts 10..29 -> t_high_meas=10, t_low_meas=30, meas_valid pulses once 3 cycles after eof, no error flags.
2. Inverted polarity: asy_ch_pol=1 latched with tdd_enable=1, `in` low for counts 10..29 -> same values as scenario 1.
3. Missing pulse: no pulse in frame 2 after a valid frame 1 -> err_no_high=1, outputs keep the frame 1 values, no meas_valid. Then clr_status -> err_no_high=0.
4. Double pulse: pulses at counts 5..9 and 40..49 -> err_extra=1, values 5/10 published. Pulse held past eof -> err_no_low=1.
5. Abort: tdd_cstate goes to IDLE at count 50 after an assertion at count 20 -> no meas_valid, no flags, FSM in M_IDLE. An async resetn pulse mid-frame -> all outputs return to 0 immediately.
6. Glitch: 2-cycle pulse at count 50 with GLITCH_CYCLES=4.
   - Macro defined: pulse ignored -> err_no_high=1.
   - Macro undefined: t_high_meas=50, t_low_meas=52.
